// File: rtl/fifo_block_stats.sv
// Read-side FIFO consumer: groups BLK_LEN signed samples per block into sum/min/max.
// Latency: result valid on the edge after the last pop (pop-to-capture is one cycle).
// Backpressure: FIFO reads stop while a result is pending, so the FIFO absorbs the stall.
module fifo_block_stats #(
    parameter int DATA_W  = 8,
    parameter int BLK_LEN = 4,
    parameter int SUM_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fifo_empty,
    output logic              fifo_r_en,
    input  logic [DATA_W-1:0] fifo_data,
    output logic [SUM_W-1:0]  sum_out,
    output logic [DATA_W-1:0] min_out,
    output logic [DATA_W-1:0] max_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       blk_cnt
);

    localparam int CW = $clog2(BLK_LEN + 1);
    localparam logic [CW-1:0] FULL = CW'(BLK_LEN);
    localparam logic [CW-1:0] LAST = CW'(BLK_LEN - 1);

    typedef enum logic {ST_FILL, ST_OUT} state_t;

    state_t                   state, state_nxt;
    logic [CW-1:0]            issued, recvd;
    logic                     cap_vld;
    logic                     pop, last_cap, accept, first;
    logic signed [DATA_W-1:0] samp, acc_min, acc_max, min_nxt, max_nxt;
    logic signed [SUM_W-1:0]  samp_ext, acc_sum, sum_nxt;

    // Running statistics including the sample being captured this cycle.
    always_comb begin
        samp     = signed'(fifo_data);
        samp_ext = {{(SUM_W-DATA_W){samp[DATA_W-1]}}, samp};
        first    = (recvd == '0);
        sum_nxt  = first ? samp_ext : acc_sum + samp_ext;
        min_nxt  = (first || samp < acc_min) ? samp : acc_min;
        max_nxt  = (first || samp > acc_max) ? samp : acc_max;
    end

    always_comb begin
        state_nxt = state;
        fifo_r_en = 1'b0;
        out_valid = 1'b0;
        case (state)
            ST_FILL: begin
                // Deliberately not gated by fifo_empty; the FIFO ignores empty reads.
                fifo_r_en = (issued < FULL);
                if (cap_vld && recvd == LAST)
                    state_nxt = ST_OUT;
            end
            ST_OUT: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = ST_FILL;
            end
            default: state_nxt = ST_FILL;
        endcase
    end

    assign pop      = fifo_r_en && !fifo_empty;
    assign last_cap = cap_vld && (recvd == LAST);
    assign accept   = (state == ST_OUT) && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_FILL;
            issued  <= '0;
            recvd   <= '0;
            cap_vld <= 1'b0;
            blk_cnt <= '0;
        end else begin
            state   <= state_nxt;
            cap_vld <= pop;
            if (accept) begin
                issued  <= '0;
                recvd   <= '0;
                blk_cnt <= blk_cnt + 16'd1;
            end else begin
                if (pop)
                    issued <= issued + CW'(1);
                if (cap_vld)
                    recvd <= recvd + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_sum <= '0;
            acc_min <= '0;
            acc_max <= '0;
            sum_out <= '0;
            min_out <= '0;
            max_out <= '0;
        end else if (cap_vld) begin
            acc_sum <= sum_nxt;
            acc_min <= min_nxt;
            acc_max <= max_nxt;
            if (last_cap) begin
                sum_out <= sum_nxt;
                min_out <= min_nxt;
                max_out <= max_nxt;
            end
        end
    end

endmodule

// File: tb/tb_fifo_block_stats.sv
// Directed bench for fifo_block_stats with a behavioural FIFO read port.
module tb_fifo_block_stats;

    logic              clk;
    logic              rst_n;
    logic              fifo_empty;
    logic              fifo_r_en;
    logic [7:0]        fifo_data;
    logic [15:0]       sum_out;
    logic [7:0]        min_out;
    logic [7:0]        max_out;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       blk_cnt;

    fifo_block_stats #(.DATA_W(8), .BLK_LEN(4), .SUM_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_r_en  (fifo_r_en),
        .fifo_data  (fifo_data),
        .sum_out    (sum_out),
        .min_out    (min_out),
        .max_out    (max_out),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .blk_cnt    (blk_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] mem [0:127];
    int         pop_cyc [0:127];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    int         cyc = 0;
    int         n_tests = 0;
    int         n_fail = 0;

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) cyc <= cyc + 1;

    // Registered data_out that advances on each effective read.
    always @(posedge clk) begin
        if (fifo_r_en && !fifo_empty) begin
            fifo_data       <= mem[rd_ptr];
            pop_cyc[rd_ptr] <= cyc;
            rd_ptr          <= rd_ptr + 1;
        end
    end

    task automatic chk(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic push(input int v);
        mem[wr_ptr] = 8'(v);
        wr_ptr++;
    endtask

    task automatic wait_valid();
        int n;
        for (n = 0; n < 60; n++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        if (n == 60) chk("valid_timeout", 0, 1);
    endtask

    task automatic chk_blk(input string tag, input int s, input int mn, input int mx);
        chk({tag, "_sum"}, longint'($signed(sum_out)), s);
        chk({tag, "_min"}, longint'($signed(min_out)), mn);
        chk({tag, "_max"}, longint'($signed(max_out)), mx);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int p;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk_blk("rst", 0, 0, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_blk_cnt", blk_cnt, 0);
        chk("rst_r_en", fifo_r_en, 1);
        rst_n = 1'b1;

        // Two back-to-back blocks, FIFO never empty, ready tied high.
        foreach (mem[i]) if (i < 0) mem[i] = 8'd0;
        push(-3); push(9); push(4); push(-8);
        push(11); push(5); push(-8); push(1);
        wait_valid();
        chk_blk("blk0", 2, -8, 9);
        wait_valid();
        chk_blk("blk1", 9, -8, 11);
        @(negedge clk);
        chk("blk_cnt_2", blk_cnt, 2);
        chk("pop_interval", pop_cyc[4] - pop_cyc[0], 6);
        chk("pop_spacing", pop_cyc[1] - pop_cyc[0], 1);

        // Backpressure: 5 cycles stalled in OUT, then accept.
        out_ready = 1'b0;
        push(1); push(2); push(3); push(4);
        push(-128); push(-128); push(-128); push(-128);
        wait_valid();
        chk_blk("bp", 10, 1, 4);
        p = rd_ptr;
        chk("bp_pops", p, 12);
        for (int i = 0; i < 5; i++) begin
            chk("bp_r_en", fifo_r_en, 0);
            chk("bp_valid", out_valid, 1);
            chk("bp_sum_hold", longint'($signed(sum_out)), 10);
            chk("bp_no_pop", rd_ptr, p);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_accept_valid", out_valid, 0);
        chk("bp_blk_cnt", blk_cnt, 3);
        chk("bp_no_pop_accept", rd_ptr, p);
        @(negedge clk);
        chk("bp_pop_after", rd_ptr, p + 1);

        // Extremes.
        wait_valid();
        chk_blk("neg", -512, -128, -128);
        push(127); push(127); push(127); push(127);
        push(-128); push(127); push(0); push(-1);
        wait_valid();
        chk_blk("pos", 508, 127, 127);
        wait_valid();
        chk_blk("mix", -2, -128, 127);

        // FIFO runs dry mid-block for 7 cycles.
        p = rd_ptr;
        push(10); push(-20);
        repeat (9) @(negedge clk);
        chk("gap_pops", rd_ptr, p + 2);
        chk("gap_r_en", fifo_r_en, 1);
        chk("gap_valid", out_valid, 0);
        push(30); push(-5);
        wait_valid();
        chk_blk("gap", 15, -20, 30);
        chk("gap_total_pops", rd_ptr, p + 4);
        @(negedge clk);
        chk("gap_blk_cnt", blk_cnt, 7);

        // Asynchronous reset after two captures discards the partial block.
        push(50); push(60);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_blk("mrst", 0, 0, 0);
        chk("mrst_blk_cnt", blk_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        push(1); push(1); push(1); push(-7);
        wait_valid();
        chk_blk("fresh", -4, -7, 1);
        @(negedge clk);
        chk("fresh_blk_cnt", blk_cnt, 1);

        // Reset while a result is pending.
        out_ready = 1'b0;
        push(2); push(2); push(2); push(2);
        wait_valid();
        #2 rst_n = 1'b0;
        #1;
        chk("orst_valid", out_valid, 0);
        chk("orst_blk_cnt", blk_cnt, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("orst_blk_cnt_after", blk_cnt, 0);
        chk("orst_valid_after", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_block_stats.md
# fifo_block_stats

Read-side consumer for the dual-clock sample FIFO, running in the FIFO read-clock domain. Pops signed 8-bit samples through the FIFO's `r_en`/`empty`/`data_out` port and groups them into fixed-length blocks. For each block it produces the signed sum, minimum and maximum, then presents them downstream on a valid/ready handshake. Downstream backpressure stalls FIFO reads, so the FIFO absorbs any rate mismatch.

## Interface
- `DATA_W`, default 8: sample width, two's-complement signed.
- `BLK_LEN`, default 4: samples per block, legal range 2..256.
- `SUM_W`, default 16: sum width; must be ≥ `DATA_W + ceil(log2(BLK_LEN))`.
- `clk  in  1`: FIFO read clock; all logic is on the rising edge.
- `rst_n  in  1`: asynchronous, active-low reset.
- `fifo_empty  in  1`: FIFO empty flag, read-domain.
- `fifo_r_en  out  1`: read enable to the FIFO; combinational.
- `fifo_data  in  DATA_W`: FIFO registered `data_out`; signed.
- `sum_out  out  SUM_W`: block sum, signed.
- `min_out  out  DATA_W`: block minimum, signed.
- `max_out  out  DATA_W`: block maximum, signed.
- `out_valid  out  1`: block result valid.
- `out_ready  in  1`: downstream accepts the result.
- `blk_cnt  out  16`: count of accepted blocks; wraps at 65535 → 0.

## Operation
- A pop occurs on an edge where `fifo_r_en && !fifo_empty`; FIFO `data_out` updates on that same edge.
- `cap_vld` is a register loaded with the pop condition. When `cap_vld` = 1, `fifo_data` is sampled on the next edge.
- Counters:
  - `issued` (0..`BLK_LEN`) counts pops.
  - `recvd` (0..`BLK_LEN`) counts captures.
- States:
  - FILL: `fifo_r_en` = (`issued` < `BLK_LEN`). It is not gated by `fifo_empty`; the FIFO ignores reads when empty. Each capture updates the accumulators.
  - FILL → OUT on the edge that performs capture number `BLK_LEN`. On that edge, `sum_out`/`min_out`/`max_out` load the final values.
  - OUT: `out_valid` = 1 and `fifo_r_en` = 0. Result registers hold stable.
  - OUT → FILL on the edge with `out_ready` = 1. On that edge: clear `issued`/`recvd`, increment `blk_cnt`, deassert `out_valid`.
- Arithmetic:
  - Samples are sign-extended to `SUM_W` before adding. No saturation is needed because `SUM_W` is sized for the worst case.
  - The first capture of a block loads min, max and sum directly from the sample. Later captures compare with signed compare.
  - On ties, the min/max value is unchanged; there is no index output.
- Empty gaps: `fifo_r_en` stays high and pops resume when `fifo_empty` falls. No sample is lost or duplicated, and block boundaries are purely count-based.
- Reset (any time, including mid-block or in OUT):
  - State goes to FILL, with `issued`, `recvd`, `cap_vld` and `blk_cnt` = 0.
  - `sum_out`, `min_out`, `max_out` = 0 and `out_valid` = 0.
  - A partial block is discarded.
  - A pop in flight at reset is dropped; the FIFO pointer has already advanced.
- `out_ready` is ignored outside OUT. `fifo_empty` is ignored in OUT.

## Timing
- Pop-to-capture latency: 1 cycle.
- Result latency: `out_valid` rises on the edge after the last pop (the last capture edge).
- Best-case throughput (FIFO never empty, `out_ready` tied high): one block per `BLK_LEN` + 2 cycles. With `BLK_LEN` = 4 the sequence is:
  - pops on E0–E3;
  - captures on E1–E4;
  - OUT after E4;
  - accept on E5;
  - next pop on E6.
- `out_valid`, once high, stays high with stable data until accepted. It never drops without a handshake except on reset.
- Boundary cases:
  - `issued` reaches `BLK_LEN`: `fifo_r_en` drops combinationally in the same cycle, so pop number `BLK_LEN + 1` never occurs.
  - `fifo_empty` rises in the same cycle as the last pop: `fifo_r_en` may remain high, but no extra pop fires.

## Test plan
- FIFO preloaded with −3, 9, 4, −8, 11, 5, −8, 1; `BLK_LEN` = 4; `out_ready` = 1 → block 0 gives sum 2, min −8, max 9. Block 1 gives sum 9, min −8, max 11. `blk_cnt` ends at 2. Pop interval is 6 cycles.
- Backpressure: hold `out_ready` = 0 for 5 cycles in OUT → `fifo_r_en` = 0 and all outputs stable for those 5 cycles. Accept on the 6th cycle; the next pop follows 1 cycle later.
- Empty gaps: FIFO goes empty after 2 samples of a block for 7 cycles → block completes correctly after the refill, with the exact count of pops and no extra pop.
- Extremes: four −128 → sum −512, min = max = −128. Four +127 → sum 508. Mixed −128, 127, 0, −1 → sum −2, min −128, max 127.
- Reset mid-block: after 2 captures, pulse `rst_n` low asynchronously between edges → all outputs 0 immediately. The next 4 samples form a fresh block with no residue from before reset.
- Reset in OUT with `out_valid` = 1 → `out_valid` = 0 immediately, `blk_cnt` stays 0, and no handshake is counted.
